// File: rtl/univ_shift_reg_pkg.sv
// rtl/univ_shift_reg_pkg.sv - mode encoding and counter width helper for univ_shift_reg
package univ_shift_pkg;

  typedef enum logic [1:0] {
    SM_HOLD = 2'b00,
    SM_SHR  = 2'b01,
    SM_SHL  = 2'b10,
    SM_LOAD = 2'b11
  } shift_mode_t;

  function automatic int CNT_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/univ_shift_reg_sat_counter.sv
// rtl/univ_shift_reg_sat_counter.sv - saturating up-counter with clear and registered at_max flag
module sat_counter
  import univ_shift_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    inc,
  output logic [CNT_W(MAX)-1:0]   cnt,
  output logic                    at_max
);

  localparam int CW = CNT_W(MAX);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (inc && (cnt != MAX_C))
      cnt_nxt = cnt + CW'(1);
  end

  // at_max compares the next value so it rises on the same edge the count lands on MAX
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      at_max <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      at_max <= (cnt_nxt == MAX_C);
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with hold/shift-right/shift-left/load and shift counter
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [WIDTH-1:0]          d_par,
  input  logic                      sin_l,
  input  logic                      sin_r,
  output logic [WIDTH-1:0]          q,
  output logic [WIDTH-1:0]          q_n,
  output logic                      sout_r,
  output logic                      sout_l,
  output logic [CNT_W(WIDTH)-1:0]   shift_cnt,
  output logic                      done
);

  shift_mode_t mode_e;
  logic        cnt_clr;
  logic        cnt_inc;

  assign mode_e = shift_mode_t'(mode);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      case (mode_e)
        SM_SHR:  q <= {sin_l, q[WIDTH-1:1]};
        SM_SHL:  q <= {q[WIDTH-2:0], sin_r};
        SM_LOAD: q <= d_par;
        default: q <= q;
      endcase
    end
  end

  // complement and serial outs derive from q so they can never disagree with it
  assign q_n    = ~q;
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  assign cnt_clr = en && (mode_e == SM_LOAD);
  assign cnt_inc = en && ((mode_e == SM_SHR) || (mode_e == SM_SHL));

  sat_counter #(
    .MAX (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .cnt    (shift_cnt),
    .at_max (done)
  );

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed and random checks of univ_shift_reg against a behavioural model
module tb_univ_shift_reg;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, en, sin_l, sin_r;
  logic [1:0]   mode;
  logic [W-1:0] d_par, q, q_n;
  logic         sout_r, sout_l, done;
  logic [2:0]   shift_cnt;

  int errors = 0;
  int checks = 0;

  int mq   = 0;
  int mcnt = 0;
  bit mvalid = 1'b0;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .d_par     (d_par),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .q         (q),
    .q_n       (q_n),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .shift_cnt (shift_cnt),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: register as an integer, shifts by arithmetic, count clipped at W
  always @(posedge clk) begin
    if (reset) begin
      mq     <= 0;
      mcnt   <= 0;
      mvalid <= 1'b1;
    end else if (en) begin
      case (mode)
        2'd1: begin
          mq   <= (mq >> 1) | (int'(sin_l) << (W - 1));
          mcnt <= (mcnt < W) ? mcnt + 1 : W;
        end
        2'd2: begin
          mq   <= ((mq << 1) | int'(sin_r)) & ((1 << W) - 1);
          mcnt <= (mcnt < W) ? mcnt + 1 : W;
        end
        2'd3: begin
          mq   <= int'(d_par);
          mcnt <= 0;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_q",      int'(q),         mq);
      chk("m_q_n",    int'(q_n),       (~mq) & ((1 << W) - 1));
      chk("m_sout_r", int'(sout_r),    mq & 1);
      chk("m_sout_l", int'(sout_l),    (mq >> (W - 1)) & 1);
      chk("m_cnt",    int'(shift_cnt), mcnt);
      chk("m_done",   int'(done),      (mcnt == W) ? 1 : 0);
    end
  end

  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [W-1:0] d, input logic sl, input logic sr);
    reset = r; en = e; mode = m; d_par = d; sin_l = sl; sin_r = sr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string tag, input int eq, input int ecnt, input int edone);
    chk({tag, "_q"},    int'(q),         eq);
    chk({tag, "_cnt"},  int'(shift_cnt), ecnt);
    chk({tag, "_done"}, int'(done),      edone);
  endtask

  initial begin
    int shr_q [4];
    shr_q = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
    reset = 1'b0; en = 1'b0; mode = 2'd0; d_par = '0; sin_l = 1'b0; sin_r = 1'b0;
    @(negedge clk);

    step(1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    lit("reset", 0, 0, 0);
    chk("reset_q_n", int'(q_n), 4'b1111);
    chk("reset_sout", int'({sout_l, sout_r}), 0);

    step(1'b0, 1'b1, 2'd3, 4'b1011, 1'b0, 1'b0);
    lit("load", 4'b1011, 0, 0);
    chk("load_q_n", int'(q_n), 4'b0100);
    chk("load_sout", int'({sout_l, sout_r}), 3);

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 2'd1, 4'h0, 1'b0, 1'b0);
      lit($sformatf("shr%0d", i), shr_q[i], i + 1, (i == 3) ? 1 : 0);
    end
    step(1'b0, 1'b1, 2'd1, 4'h0, 1'b0, 1'b0);
    lit("shr_sat", 4'b0000, 4, 1);

    step(1'b0, 1'b1, 2'd2, 4'h0, 1'b0, 1'b1);
    lit("shl0", 4'b0001, 4, 1);
    step(1'b0, 1'b1, 2'd2, 4'h0, 1'b0, 1'b1);
    lit("shl1", 4'b0011, 4, 1);

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd3, 4'b1111, 1'b1, 1'b1);
      lit($sformatf("en0_%0d", i), 4'b0011, 4, 1);
    end

    step(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 1'b1);
    lit("hold", 4'b0011, 4, 1);

    step(1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b0);
    lit("load2", 4'b1000, 0, 0);
    step(1'b0, 1'b1, 2'd1, 4'h0, 1'b1, 1'b0);
    lit("mix_shr", 4'b1100, 1, 0);
    step(1'b0, 1'b1, 2'd2, 4'h0, 1'b0, 1'b0);
    lit("mix_shl", 4'b1000, 2, 0);

    step(1'b1, 1'b1, 2'd3, 4'b1010, 1'b0, 1'b0);
    lit("rst_wins", 0, 0, 0);

    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 19) == 0), 1'($urandom), 2'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
